core_seq_ctrl: RTL

//  Multi-cycle sequencer for the RV32 integer/M-extension core. Fetches from instruction memory, holds
//  the instruction register feeding the instruction decoder, sequences the ALU, launches the multi-cycle
//  mul/div unit and gates the register-file write. Sits between imem, decoder, ALU, mul/div and regfile.

---
 rtl/core_seq_ctrl_if.sv | 23 ++
 rtl/core_seq_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl_if.sv
// rtl/core_seq_ctrl_if.sv - imem fetch and mul/div handshake bundle for core_seq_ctrl
interface core_seq_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              md_start;
    logic              md_done;

    // Sequencer side: issues fetches and mul/div launches.
    modport master (
        output imem_req, imem_addr, md_start,
        input  imem_ack, imem_rdata, md_done
    );

    // Memory / mul-div side: answers fetches and reports completion.
    modport slave (
        input  imem_req, imem_addr, md_start,
        output imem_ack, imem_rdata, md_done
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle RV32IM sequencer; optional SEQ_PERF_CNT_EN adds cyc_cnt/ret_cnt
module core_seq_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                MD_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    core_seq_ctrl_if.master    bus,
    output logic [31:0]        instr,
    input  logic               dec_reg_write,
    output logic               alu_en,
    output logic               rf_we,
    output logic               retire,
    output logic [ADDR_W-1:0]  pc,
    output logic               trap,
    output logic [1:0]         trap_cause
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        ret_cnt
`endif
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MD_TMO  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MD_WAIT,
        WB,
        TRAP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         cause_nxt;
    logic [CNT_W-1:0]   md_cnt;

    logic [6:0] opcode;
    logic       is_r;
    logic       is_legal;
    logic       md_first;
    logic       md_last;

    assign opcode   = instr[6:0];
    assign is_r     = (opcode == OP_R);
    assign is_legal = is_r || (opcode == OP_I);
    // md_cnt is zero only in the launch cycle, so it doubles as the md_start qualifier.
    assign md_first = (md_cnt == '0);
    assign md_last  = (md_cnt == CNT_W'(MD_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and the trap cause to latch on entry to TRAP.
    always_comb begin
        state_nxt = state;
        cause_nxt = 2'b00;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) state_nxt = DECODE;
            end
            DECODE: begin
                if (!is_legal) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (is_r && instr[25]) begin
                    state_nxt = MD_WAIT;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = WB;
            end
            MD_WAIT: begin
                // A done seen in the launch cycle belongs to nothing we started; completion
                // beats timeout when both land together.
                if (!md_first && bus.md_done) begin
                    state_nxt = WB;
                end else if (md_last) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_MD_TMO;
                end
            end
            WB: begin
                state_nxt = run ? FETCH : IDLE;
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Instruction register, pc, mul/div wait counter and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= '0;
            md_cnt     <= '0;
            trap_cause <= 2'b00;
        end else begin
            if (state == FETCH && bus.imem_ack) begin
                instr <= bus.imem_rdata;
            end
            if (state == WB) begin
                pc <= pc + ADDR_W'(4);
            end
            if (state == MD_WAIT) begin
                md_cnt <= md_cnt + CNT_W'(1);
            end else begin
                md_cnt <= '0;
            end
            if (state != TRAP && state_nxt == TRAP) begin
                trap_cause <= cause_nxt;
            end
        end
    end

    assign bus.imem_req  = (state == FETCH);
    assign bus.imem_addr = pc;
    assign bus.md_start  = (state == MD_WAIT) && md_first;
    assign alu_en        = (state == EXEC);
    assign retire        = (state == WB);
    assign rf_we         = (state == WB) && dec_reg_write && (instr[11:7] != 5'd0);
    assign trap          = (state == TRAP);

`ifdef SEQ_PERF_CNT_EN
    // Active-cycle and retired-instruction counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != IDLE && state != TRAP) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (retire) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
